axis_stall_detector: RTL and testbench

AXIS_STALL_DETECTOR -- requirements
Module: axis_stall_detector

---
 rtl/axis_stall_detector_pkg.sv | 10 +
 rtl/axis_stall_chan.sv | 56 +++++
 rtl/axis_stall_detector.sv | 96 +++++++++
 tb/tb_axis_stall_detector.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/axis_stall_detector_pkg.sv
// Shared types for the AXI-Stream stall detector: per-channel FSM states and channel limit.
package axis_stall_detector_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STALL   = 2'd1,
      BLOCKED = 2'd2
   } chan_state_t;

   localparam int MAX_CH = 32;
endpackage

// File: rtl/axis_stall_chan.sv
// One monitored channel: counts consecutive stalled edges and flags BLOCKED at THRESHOLD.
// Next-state/count are exported so the top can capture on the entering edge.
module axis_stall_chan
   import axis_stall_detector_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int THRESHOLD = 1024
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             tvalid,
   input  logic             tready,
   output logic             block,
   output logic             enter,
   output logic             blk_nxt,
   output logic [CNT_W-1:0] cnt_nxt
);
   chan_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             stalled;
   logic             at_thr;

   assign stalled = tvalid & ~tready & enable;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
      at_thr    = 1'b0;
      if (stalled) begin
         cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
         at_thr  = (cnt_nxt == CNT_W'(THRESHOLD));
         case (state)
            // THRESHOLD=1 lets IDLE jump straight to BLOCKED on the first stalled edge
            IDLE:    state_nxt = at_thr ? BLOCKED : STALL;
            STALL:   state_nxt = at_thr ? BLOCKED : STALL;
            BLOCKED: state_nxt = BLOCKED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign block   = (state == BLOCKED);
   assign blk_nxt = (state_nxt == BLOCKED);
   assign enter   = blk_nxt & ~block;
endmodule

// File: rtl/axis_stall_detector.sv
// Multi-channel AXI-Stream stall detector: per-channel blocked flags plus a sticky
// first-block capture (channel index and frozen stall length), cleared by status_clr.
module axis_stall_detector
   import axis_stall_detector_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int CNT_W     = 16,
   parameter int THRESHOLD = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] ch_tvalid,
   input  logic [NUM_CH-1:0] ch_tready,
   input  logic              status_clr,
   output logic [NUM_CH-1:0] axis_block_sigs,
   output logic              any_block,
   output logic              first_valid,
   output logic [4:0]        first_ch,
   output logic [CNT_W-1:0]  first_len
);
   logic [NUM_CH-1:0] enter;
   logic [NUM_CH-1:0] blk_nxt;
   logic [CNT_W-1:0]  cnt_nxt [NUM_CH];

   logic              found;
   logic [4:0]        sel;
   logic [CNT_W-1:0]  sel_cnt;
   logic              trk_blk;
   logic [CNT_W-1:0]  trk_cnt;
   logic              tracking;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      axis_stall_chan #(
         .CNT_W     (CNT_W),
         .THRESHOLD (THRESHOLD)
      ) u_chan (
         .clock   (clock),
         .reset   (reset),
         .enable  (enable),
         .tvalid  (ch_tvalid[g]),
         .tready  (ch_tready[g]),
         .block   (axis_block_sigs[g]),
         .enter   (enter[g]),
         .blk_nxt (blk_nxt[g]),
         .cnt_nxt (cnt_nxt[g])
      );
   end

   // Block bits come straight from state flops, so the OR lines up with them.
   assign any_block = |axis_block_sigs;

   always_comb begin
      found   = 1'b0;
      sel     = '0;
      sel_cnt = '0;
      trk_blk = 1'b0;
      trk_cnt = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (enter[i]) begin
            found   = 1'b1;
            sel     = 5'(i);
            sel_cnt = cnt_nxt[i];
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (first_ch == 5'(i)) begin
            trk_blk = blk_nxt[i];
            trk_cnt = cnt_nxt[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         first_valid <= 1'b0;
         first_ch    <= '0;
         first_len   <= '0;
         tracking    <= 1'b0;
      end else if ((~first_valid | status_clr) & found) begin
         first_valid <= 1'b1;
         first_ch    <= sel;
         first_len   <= sel_cnt;
         tracking    <= 1'b1;
      end else if (status_clr) begin
         first_valid <= 1'b0;
         first_ch    <= '0;
         first_len   <= '0;
         tracking    <= 1'b0;
      end else if (tracking) begin
         // Length freezes once the captured channel leaves BLOCKED, even if it re-blocks later.
         if (trk_blk) first_len <= trk_cnt;
         else         tracking  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axis_stall_detector.sv
// Directed bench: three detector instances (THR=4, CNT_W=3/THR=5, THR=1) share one stimulus.
module tb_axis_stall_detector;
   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] ch_tvalid;
   logic [1:0] ch_tready;
   logic       status_clr;

   logic [1:0]  a_blk, b_blk, c_blk;
   logic        a_any, b_any, c_any;
   logic        a_fv, b_fv, c_fv;
   logic [4:0]  a_fch, b_fch, c_fch;
   logic [15:0] a_flen, c_flen;
   logic [2:0]  b_flen;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   axis_stall_detector #(.NUM_CH(2), .CNT_W(16), .THRESHOLD(4)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .ch_tvalid(ch_tvalid),
      .ch_tready(ch_tready), .status_clr(status_clr), .axis_block_sigs(a_blk),
      .any_block(a_any), .first_valid(a_fv), .first_ch(a_fch), .first_len(a_flen));

   axis_stall_detector #(.NUM_CH(2), .CNT_W(3), .THRESHOLD(5)) dut_b (
      .clock(clock), .reset(reset), .enable(enable), .ch_tvalid(ch_tvalid),
      .ch_tready(ch_tready), .status_clr(status_clr), .axis_block_sigs(b_blk),
      .any_block(b_any), .first_valid(b_fv), .first_ch(b_fch), .first_len(b_flen));

   axis_stall_detector #(.NUM_CH(2), .CNT_W(16), .THRESHOLD(1)) dut_c (
      .clock(clock), .reset(reset), .enable(enable), .ch_tvalid(ch_tvalid),
      .ch_tready(ch_tready), .status_clr(status_clr), .axis_block_sigs(c_blk),
      .any_block(c_any), .first_valid(c_fv), .first_ch(c_fch), .first_len(c_flen));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_pulse();
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; ch_tvalid = 2'b00; ch_tready = 2'b00; status_clr = 1'b0;
      tick();
      chk("rst_blk",  a_blk,  0);
      chk("rst_any",  a_any,  0);
      chk("rst_fv",   a_fv,   0);
      chk("rst_fch",  a_fch,  0);
      chk("rst_flen", a_flen, 0);
      reset = 1'b0;
      tick();

      // ch0 stalled for six edges
      ch_tvalid = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("s6_blk_e%0d", k), a_blk, (k >= 4) ? 2'b01 : 2'b00);
         chk($sformatf("thr5_blk_e%0d", k), b_blk, (k >= 5) ? 2'b01 : 2'b00);
         if (k == 1) chk("thr1_blk", c_blk, 2'b01);
      end
      chk("s6_any",  a_any,  1);
      chk("s6_fv",   a_fv,   1);
      chk("s6_fch",  a_fch,  0);
      chk("s6_flen", a_flen, 6);
      ch_tvalid = 2'b00;
      tick();
      chk("s6_fall",      a_blk,  2'b00);
      chk("s6_flen_hold", a_flen, 6);
      clear_pulse();
      chk("clr_fv", a_fv, 0);

      // ch1: 3 stalls, one handshake, 3 stalls: never blocks
      ch_tvalid = 2'b10;
      for (int k = 1; k <= 7; k++) begin
         ch_tready = (k == 4) ? 2'b10 : 2'b00;
         tick();
         chk($sformatf("hs_blk_e%0d", k), a_blk, 2'b00);
      end
      ch_tvalid = 2'b00; ch_tready = 2'b00;
      tick();
      clear_pulse();

      // both channels stall together: lowest index captured
      ch_tvalid = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("dual_blk_e%0d", k), a_blk, (k == 4) ? 2'b11 : 2'b00);
      end
      chk("dual_fch", a_fch, 0);
      ch_tvalid = 2'b00;
      tick();
      clear_pulse();
      chk("dual_clr_fv", a_fv, 0);
      ch_tvalid = 2'b10;
      repeat (4) tick();
      chk("ch1_blk", a_blk, 2'b10);
      chk("ch1_fv",  a_fv,  1);
      chk("ch1_fch", a_fch, 1);
      ch_tvalid = 2'b00;
      tick();

      // clear coinciding with a fresh capture on ch0
      ch_tvalid = 2'b01;
      repeat (3) tick();
      chk("coin_pre_fch", a_fch, 1);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      chk("coin_fv",   a_fv,   1);
      chk("coin_fch",  a_fch,  0);
      chk("coin_flen", a_flen, 4);
      ch_tvalid = 2'b00;
      tick();
      clear_pulse();

      // long ch0 stall: CNT_W=3 instance saturates at 7
      ch_tvalid = 2'b01;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 4)  chk("sat_blk_e4",  b_blk, 2'b00);
         if (k == 5)  chk("sat_blk_e5",  b_blk, 2'b01);
         if (k == 20) chk("sat_blk_e20", b_blk, 2'b01);
      end
      chk("sat_flen", b_flen, 7);
      chk("sat_fch",  b_fch,  0);
      chk("sat_fv",   b_fv,   1);

      // reset while blocked, stall continues
      chk("pre_rst_blk", a_blk, 2'b01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_blk",  a_blk,  2'b00);
      chk("mid_rst_any",  a_any,  0);
      chk("mid_rst_fv",   a_fv,   0);
      chk("mid_rst_flen", a_flen, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("reblk_e%0d", k), a_blk, (k == 4) ? 2'b01 : 2'b00);
      end
      chk("reblk_fv", a_fv, 1);

      // drop enable while blocked
      enable = 1'b0;
      tick();
      chk("en_blk", a_blk, 2'b00);
      chk("en_any", a_any, 0);
      chk("en_fv",  a_fv,  1);
      chk("en_fch", a_fch, 0);
      enable = 1'b1;
      ch_tvalid = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
